// File: rtl/seq_product_divider.sv
// Multi-cycle restoring divider: recovers Q = P / B and R = P % B, one quotient bit per clock.
// Define DIVIDER_SELFCHECK_EN to add the chk_err output (Q*B + R re-multiplied against P).
module seq_product_divider #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   P,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]     R,
    output logic                 div_by_zero
`ifdef DIVIDER_SELFCHECK_EN
    ,
    output logic                 chk_err
`endif
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0]    r_pr;      // after a restore the remainder is < B, so WIDTH bits suffice
    logic [WIDTH-1:0]    r_b;
    logic [CW-1:0]       r_cnt;

    logic [WIDTH:0]      w_pr_shift;
    logic                w_ge;
    logic [WIDTH:0]      w_pr_next;
    logic [DW-1:0]       w_q_final;

    // One restoring step: shift in the next dividend bit, subtract B when it fits.
    always_comb begin
        w_pr_shift = {r_pr, r_dvd[DW-1]};
        w_ge       = (w_pr_shift >= {1'b0, r_b});
        if (w_ge) begin
            w_pr_next = w_pr_shift - {1'b0, r_b};
        end else begin
            w_pr_next = w_pr_shift;
        end
        w_q_final  = {r_dvd[DW-2:0], w_ge};
    end

`ifdef DIVIDER_SELFCHECK_EN
    localparam int PW = 3 * WIDTH;
    logic [DW-1:0]       r_p;
    logic [PW-1:0]       w_recon;
    logic                w_mis;

    // Reconstruct the dividend from the final quotient/remainder of this step.
    always_comb begin
        w_recon = PW'(w_q_final) * PW'(r_b) + PW'(w_pr_next[WIDTH-1:0]);
        w_mis   = (w_recon != PW'(r_p));
    end
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dvd       <= {DW{1'b0}};
            r_pr        <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= {DW{1'b0}};
            R           <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SELFCHECK_EN
            r_p         <= {DW{1'b0}};
            chk_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
`ifdef DIVIDER_SELFCHECK_EN
                        chk_err <= 1'b0;
                        r_p     <= P;
`endif
                        if (B != {WIDTH{1'b0}}) begin
                            r_dvd   <= P;
                            r_b     <= B;
                            r_pr    <= {WIDTH{1'b0}};
                            r_cnt   <= {CW{1'b0}};
                            r_state <= S_CALC;
                        end else begin
                            Q           <= {DW{1'b1}};
                            R           <= {WIDTH{1'b0}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_pr  <= w_pr_next[WIDTH-1:0];
                    r_dvd <= w_q_final;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        Q           <= w_q_final;
                        R           <= w_pr_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
`ifdef DIVIDER_SELFCHECK_EN
                        chk_err     <= w_mis;
`endif
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_product_divider.sv
// Directed self-checking bench for seq_product_divider (WIDTH=2).
module tb_seq_product_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] P;
    logic [1:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [1:0] R;
    logic       div_by_zero;
`ifdef DIVIDER_SELFCHECK_EN
    logic       chk_err;
`endif

    int n_checks = 0;
    int n_err    = 0;

    seq_product_divider #(.WIDTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .P           (P),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
`ifdef DIVIDER_SELFCHECK_EN
        ,
        .chk_err     (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic start_div(input logic [3:0] p, input logic [1:0] b);
        @(negedge clk);
        P     = p;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = 1;
        bcnt  = 0;
        while (1) begin
            if (busy) bcnt++;
            if (done || edges >= 20) break;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_div(input string tag, input logic [3:0] p, input logic [1:0] b,
                           input logic [3:0] eq, input logic [1:0] er, input logic edz,
                           input int eedges);
        int edges;
        int bcnt;
        start_div(p, b);
        wait_done(edges, bcnt);
        chk({tag, ".latency"}, edges, eedges);
        chk({tag, ".busy_cycles"}, bcnt, eedges);
        chk({tag, ".Q"}, Q, eq);
        chk({tag, ".R"}, R, er);
        chk({tag, ".dbz"}, div_by_zero, edz);
`ifdef DIVIDER_SELFCHECK_EN
        chk({tag, ".chk_err"}, chk_err, 1'b0);
`endif
    endtask

    initial begin
        int pulses;
        logic [3:0] q_seen;
        logic [1:0] r_seen;

        rst_n = 1'b0;
        start = 1'b0;
        P     = 4'd0;
        B     = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.Q", Q, 4'd0);
        chk("reset.R", R, 2'd0);
        chk("reset.dbz", div_by_zero, 1'b0);
`ifdef DIVIDER_SELFCHECK_EN
        chk("reset.chk_err", chk_err, 1'b0);
`endif
        rst_n = 1'b1;

        // Basic divisions; the second and third starts follow done immediately.
        run_div("d9_3", 4'd9, 2'd3, 4'd3, 2'd0, 1'b0, 5);
        run_div("d7_2", 4'd7, 2'd2, 4'd3, 2'd1, 1'b0, 5);
        run_div("d15_1", 4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 5);

        // Results hold while idle.
        repeat (4) @(negedge clk);
        chk("idle_hold.busy", busy, 1'b0);
        chk("idle_hold.Q", Q, 4'd15);
        chk("idle_hold.R", R, 2'd0);

        // Divide by zero, then a valid division clears the flag.
        run_div("d6_0", 4'd6, 2'd0, 4'hF, 2'd0, 1'b1, 1);
        @(negedge clk);
        chk("dbz_idle.busy", busy, 1'b0);
        chk("dbz_idle.done", done, 1'b0);
        run_div("d7_2b", 4'd7, 2'd2, 4'd3, 2'd1, 1'b0, 5);

        // Starts at edges 2 and 3 with new operands must be ignored.
        start_div(4'd9, 2'd3);
        P = 4'd15; B = 2'd1; start = 1'b1;
        @(negedge clk);
        P = 4'd6;  B = 2'd0;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        q_seen = 4'd0;
        r_seen = 2'd0;
        repeat (10) begin
            if (done) begin
                pulses++;
                q_seen = Q;
                r_seen = R;
            end
            @(negedge clk);
        end
        chk("ignore.pulses", pulses, 1);
        chk("ignore.Q", q_seen, 4'd3);
        chk("ignore.R", r_seen, 2'd0);
        chk("ignore.dbz", div_by_zero, 1'b0);
        chk("ignore.busy", busy, 1'b0);

        // Reset at edge 3 of a division aborts it without a done pulse.
        start_div(4'd11, 2'd2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.Q", Q, 4'd0);
        chk("abort.R", R, 2'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort.no_done", pulses, 0);
        run_div("d11_2", 4'd11, 2'd2, 4'd5, 2'd1, 1'b0, 5);

        // Full sweep of operand pairs against reference division.
        for (int p = 0; p < 16; p++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 0) begin
                    run_div("sweep", 4'(p), 2'(b), 4'hF, 2'd0, 1'b1, 1);
                end else begin
                    run_div("sweep", 4'(p), 2'(b), 4'(p / b), 2'(p % b), 1'b0, 5);
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
